hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

Generates the hazard/stall control for the 5-stage RISC-V pipeline: detects load-use dependencies, taken-branch flushes and data-memory wait states, and drives the `Hazard` select of the ID-stage control bubble mux plus the PC and IF/ID write enables and flushes. It sits in the ID stage and observes ID/EX, EX and MEM state. A small FSM with a stall counter extends load-use stalls for multi-cycle memory latency.

## Interface
- Clock `clk_i`, single clock domain; reset `rst_n_i`, asynchronous, active-low.

Parameters:
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard; legal range 1..15.
- `CNT_W`, default 32: width of the performance stall counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `IDEX_MemRead_i`  in  1  the instruction in EX is a load.
- `IDEX_Rd_i`  in  5  destination register of the instruction in EX.
- `IFID_Rs1_i`  in  5  rs1 of the instruction in ID.
- `IFID_Rs2_i`  in  5  rs2 of the instruction in ID.
- `IFID_UsesRs2_i`  in  1  the instruction in ID reads rs2 (R/S/B types).
- `BranchTaken_i`  in  1  a branch or jump resolved taken in EX this cycle.
- `MemBusy_i`  in  1  data memory is not ready; freeze the whole pipe.
- `Hazard_o`  out  1  bubble select for the control mux; 1 zeroes the ID/EX control.
- `PCWrite_o`  out  1  PC register write enable.
- `IFIDWrite_o`  out  1  IF/ID register write enable.
- `IFIDFlush_o`  out  1  clear IF/ID to a NOP.
- `Stall_o`  out  1  global freeze of ID/EX, EX/MEM and MEM/WB.
- `StallCnt_o`  out  `CNT_W`  count of stall/bubble cycles (see Configuration).

## Operation
- FSM states and their behaviour:
  - RUN: normal issue.
  - LOAD_STALL: extended load-use stall, down-counter `cnt`.
  - MEM_WAIT: memory freeze.
- Load-use detection (`lu`): `IDEX_MemRead_i && IDEX_Rd_i != 0 && (IDEX_Rd_i == IFID_Rs1_i || (IFID_UsesRs2_i && IDEX_Rd_i == IFID_Rs2_i))`. `x0` never triggers a hazard.
- Input priority each cycle, highest first:
  1. `MemBusy_i`
  2. `BranchTaken_i`
  3. `lu` / LOAD_STALL
  4. idle
- `MemBusy_i`=1, from any state:
  - Outputs: `Stall_o`=1, `PCWrite_o`=0, `IFIDWrite_o`=0, `Hazard_o`=0, `IFIDFlush_o`=0.
  - The FSM enters or stays in MEM_WAIT. It saves the pre-freeze state and `cnt`, and the saved `cnt` does not decrement.
  - When `MemBusy_i` drops, the FSM returns to the saved state and `cnt`.
- `BranchTaken_i`=1, not busy:
  - Outputs: `IFIDFlush_o`=1, `Hazard_o`=1, `PCWrite_o`=1 (PC loads the target), `IFIDWrite_o`=1.
  - Any `lu` in the same cycle is ignored because the ID instruction is squashed.
  - A pending LOAD_STALL is aborted and the next state is RUN.
- `lu`=1 in RUN, not busy, no branch:
  - Outputs: `Hazard_o`=1, `PCWrite_o`=0, `IFIDWrite_o`=0.
  - If `LOAD_STALL_CYCLES`>1: next state is LOAD_STALL with `cnt`=`LOAD_STALL_CYCLES`-2.
- LOAD_STALL:
  - Same outputs as `lu`.
  - When `cnt`==0 the next state is RUN; otherwise `cnt` decrements.
  - `lu` is not re-evaluated in this state.
- RUN with no event: `PCWrite_o`=1, `IFIDWrite_o`=1; all other outputs 0.
- Outputs are combinational from state and inputs. There is no combinational path from any output back to any input.

## Timing
- Load-use detected in cycle T:
  - Bubble and PC/IF-ID hold appear in cycle T (zero latency).
  - Bubbles occupy T .. T+`LOAD_STALL_CYCLES`-1.
  - PC/IF-ID write resumes in cycle T+`LOAD_STALL_CYCLES`.
- Branch taken in T: flush is asserted in T only, for exactly one cycle.
- `MemBusy_i` freeze: outputs follow `MemBusy_i` in the same cycle with no added latency.
- Reset:
  - While `rst_n_i`=0: state RUN, `cnt`=0, counter 0.
  - All outputs are 0, including `PCWrite_o` and `IFIDWrite_o`.
  - Reset asserted mid-LOAD_STALL or mid-MEM_WAIT discards the stall. The first cycle after release is RUN.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `StallCnt_o` is a `CNT_W`-bit register.
  - It increments on every cycle with `Hazard_o`=1 or `Stall_o`=1.
  - It saturates at all-ones and is cleared only by reset.
- `HAZARD_PERF_CNT_EN` not defined: no counter logic; `StallCnt_o` is tied to 0. The port list is unchanged.

## Test plan
- Load-use, `LOAD_STALL_CYCLES`=1: `IDEX_MemRead_i`=1, `IDEX_Rd_i`=5, `IFID_Rs1_i`=5 -> one cycle of `Hazard_o`=1, `PCWrite_o`=0, `IFIDWrite_o`=0, then RUN outputs.
- `x0` and rs2 gating:
  - `IDEX_Rd_i`=0 matching `IFID_Rs1_i`=0 -> no hazard.
  - `IDEX_Rd_i`=7, `IFID_Rs2_i`=7, `IFID_UsesRs2_i`=0 -> no hazard.
  - Same with `IFID_UsesRs2_i`=1 -> hazard.
- `LOAD_STALL_CYCLES`=3, with `MemBusy_i` pulsed high for 2 cycles during the second bubble -> exactly 3 bubble cycles and 2 `Stall_o` cycles. `PCWrite_o` is re-enabled 5 cycles after detection.
- `BranchTaken_i`=1 together with `lu`=1 -> `IFIDFlush_o`=1, `Hazard_o`=1, `PCWrite_o`=1 for one cycle; no load stall follows.
- `rst_n_i` asserted asynchronously mid-LOAD_STALL -> all outputs 0 immediately; after release, state is RUN and `StallCnt_o`=0.
- `HAZARD_PERF_CNT_EN` with `CNT_W`=4, 20 stall cycles -> `StallCnt_o`=15. Without the macro -> `StallCnt_o`=0.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Hazard/stall control for the 5-stage RISC-V pipeline: load-use bubbles, branch flushes, memory freeze.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_detection_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rd_i,
    input  logic [4:0]       IFID_Rs1_i,
    input  logic [4:0]       IFID_Rs2_i,
    input  logic             IFID_UsesRs2_i,
    input  logic             BranchTaken_i,
    input  logic             MemBusy_i,
    output logic             Hazard_o,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IFIDFlush_o,
    output logic             Stall_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        MEM_WAIT
    } state_t;

    // The first bubble is issued from RUN, so the counter covers the remaining ones minus one.
    localparam logic [3:0] STALL_INIT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

    state_t     state;
    state_t     saved_state;
    state_t     eff_state;
    logic [3:0] cnt;
    logic       lu;

    assign lu = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                ((IDEX_Rd_i == IFID_Rs1_i) || (IFID_UsesRs2_i && (IDEX_Rd_i == IFID_Rs2_i)));

    // While frozen, cnt is left untouched, so on release the saved state resumes
    // in the same cycle with its counter intact.
    assign eff_state = (state == MEM_WAIT) ? saved_state : state;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        Hazard_o    = 1'b0;
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        IFIDFlush_o = 1'b0;
        Stall_o     = 1'b0;
        if (rst_n_i) begin
            if (MemBusy_i) begin
                Stall_o = 1'b1;
            end else if (BranchTaken_i) begin
                IFIDFlush_o = 1'b1;
                Hazard_o    = 1'b1;
                PCWrite_o   = 1'b1;
                IFIDWrite_o = 1'b1;
            end else if (eff_state == LOAD_STALL || lu) begin
                Hazard_o = 1'b1;
            end else begin
                PCWrite_o   = 1'b1;
                IFIDWrite_o = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= RUN;
            saved_state <= RUN;
            cnt         <= 4'd0;
        end else if (MemBusy_i) begin
            state <= MEM_WAIT;
            if (state != MEM_WAIT) saved_state <= state;
        end else if (BranchTaken_i) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else if (eff_state == LOAD_STALL) begin
            if (cnt == 4'd0) begin
                state <= RUN;
            end else begin
                state <= LOAD_STALL;
                cnt   <= cnt - 4'd1;
            end
        end else if (lu && LOAD_STALL_CYCLES > 1) begin
            state <= LOAD_STALL;
            cnt   <= STALL_INIT;
        end else begin
            state <= RUN;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of cycles where the pipe issued a bubble or froze.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt <= '0;
        end else if ((Hazard_o || Stall_o) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign StallCnt_o = stall_cnt;
`else
    assign StallCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: one instance with LOAD_STALL_CYCLES=1,
// one with LOAD_STALL_CYCLES=3 and a 4-bit counter; expected outputs go through a scoreboard queue.
module tb_hazard_detection_unit;

    typedef struct packed {
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses2;
        logic       branch;
        logic       busy;
    } in_t;

    typedef struct {
        bit         sel_b;
        logic [4:0] exp;
        string      name;
    } sb_t;

    // Output vector order: {Hazard, PCWrite, IFIDWrite, IFIDFlush, Stall}
    localparam logic [4:0] RUN_O = 5'b01100;
    localparam logic [4:0] BUB   = 5'b10000;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] FRZ   = 5'b00001;
    localparam logic [4:0] ZERO  = 5'b00000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  in_a = '0;
    in_t  in_b = '0;

    logic        haz_a, pcw_a, ifw_a, fl_a, st_a;
    logic        haz_b, pcw_b, ifw_b, fl_b, st_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .IDEX_MemRead_i(in_a.memread), .IDEX_Rd_i(in_a.rd),
        .IFID_Rs1_i(in_a.rs1), .IFID_Rs2_i(in_a.rs2), .IFID_UsesRs2_i(in_a.uses2),
        .BranchTaken_i(in_a.branch), .MemBusy_i(in_a.busy),
        .Hazard_o(haz_a), .PCWrite_o(pcw_a), .IFIDWrite_o(ifw_a),
        .IFIDFlush_o(fl_a), .Stall_o(st_a), .StallCnt_o(cnt_a)
    );

    hazard_detection_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .IDEX_MemRead_i(in_b.memread), .IDEX_Rd_i(in_b.rd),
        .IFID_Rs1_i(in_b.rs1), .IFID_Rs2_i(in_b.rs2), .IFID_UsesRs2_i(in_b.uses2),
        .BranchTaken_i(in_b.branch), .MemBusy_i(in_b.busy),
        .Hazard_o(haz_b), .PCWrite_o(pcw_b), .IFIDWrite_o(ifw_b),
        .IFIDFlush_o(fl_b), .Stall_o(st_b), .StallCnt_o(cnt_b)
    );

    wire [4:0] out_a = {haz_a, pcw_a, ifw_a, fl_a, st_a};
    wire [4:0] out_b = {haz_b, pcw_b, ifw_b, fl_b, st_b};

    function automatic in_t mk(input logic memread, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic uses2, input logic branch,
                               input logic busy);
        in_t v;
        v.memread = memread; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.uses2 = uses2; v.branch = branch; v.busy = busy;
        return v;
    endfunction

    // Drive one cycle on the selected instance (the other idles), sample on the falling edge.
    task automatic step(input bit sel_b, input in_t stim, input logic [4:0] exp, input string name);
        sb_t e;
        if (sel_b) begin in_b = stim; in_a = '0; end
        else       begin in_a = stim; in_b = '0; end
        sb_q.push_back('{sel_b, exp, name});
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks += 2;
        if (e.sel_b) begin
            if (out_b !== e.exp) begin
                n_fail++;
                $display("FAIL %s: dut_b outputs %b, required %b", e.name, out_b, e.exp);
            end
            if (out_a !== RUN_O) begin
                n_fail++;
                $display("FAIL %s idle: dut_a outputs %b, required %b", e.name, out_a, RUN_O);
            end
        end else begin
            if (out_a !== e.exp) begin
                n_fail++;
                $display("FAIL %s: dut_a outputs %b, required %b", e.name, out_a, e.exp);
            end
            if (out_b !== RUN_O) begin
                n_fail++;
                $display("FAIL %s idle: dut_b outputs %b, required %b", e.name, out_b, RUN_O);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_a = '0;
        in_b = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_a = '0;
        in_b = '0;
        rst_n = 1'b0;
        #12;
        n_checks += 4;
        if (out_a !== ZERO) begin n_fail++; $display("FAIL reset_out_a: got %b, required %b", out_a, ZERO); end
        if (out_b !== ZERO) begin n_fail++; $display("FAIL reset_out_b: got %b, required %b", out_b, ZERO); end
        if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %0d, required 0", cnt_a); end
        if (cnt_b !== 4'd0) begin n_fail++; $display("FAIL reset_cnt_b: got %0d, required 0", cnt_b); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, '0, RUN_O, "run_after_reset");
    endtask

    task automatic test_load_use_single();
        step(0, mk(1, 5'd5, 5'd5, 5'd0, 0, 0, 0), BUB, "lu1_bubble");
        step(0, '0, RUN_O, "lu1_resume");
        step(0, mk(1, 5'd9, 5'd9, 5'd0, 0, 0, 0), BUB, "lu1_b2b_first");
        step(0, mk(1, 5'd9, 5'd9, 5'd0, 0, 0, 0), BUB, "lu1_b2b_redetect");
        step(0, '0, RUN_O, "lu1_b2b_resume");
    endtask

    task automatic test_x0_rs2();
        step(0, mk(1, 5'd0, 5'd0, 5'd0, 1, 0, 0), RUN_O, "x0_no_hazard");
        step(0, mk(1, 5'd7, 5'd1, 5'd7, 0, 0, 0), RUN_O, "rs2_unused");
        step(0, mk(1, 5'd7, 5'd1, 5'd7, 1, 0, 0), BUB, "rs2_used");
        step(0, mk(0, 5'd7, 5'd7, 5'd7, 1, 0, 0), RUN_O, "no_load");
        step(0, '0, RUN_O, "x0_rs2_idle");
    endtask

    task automatic test_load_stall_multi();
        in_t lu3;
        lu3 = mk(1, 5'd12, 5'd12, 5'd0, 0, 0, 0);
        step(1, lu3, BUB, "lu3_bubble0");
        step(1, lu3, BUB, "lu3_bubble1");
        step(1, lu3, BUB, "lu3_bubble2");
        step(1, '0, RUN_O, "lu3_resume");
        // Freeze in the middle of the stall; lu stays asserted to show it is not re-evaluated.
        step(1, lu3, BUB, "lu3m_bubble0");
        step(1, lu3, BUB, "lu3m_bubble1");
        step(1, mk(1, 5'd12, 5'd12, 5'd0, 0, 0, 1), FRZ, "lu3m_freeze0");
        step(1, mk(1, 5'd12, 5'd12, 5'd0, 0, 0, 1), FRZ, "lu3m_freeze1");
        step(1, lu3, BUB, "lu3m_bubble2");
        step(1, '0, RUN_O, "lu3m_resume_t5");
    endtask

    task automatic test_branch();
        step(0, mk(1, 5'd5, 5'd5, 5'd0, 0, 1, 0), FLUSH, "br_lu_a");
        step(0, '0, RUN_O, "br_lu_a_after");
        step(1, mk(1, 5'd5, 5'd5, 5'd0, 0, 1, 0), FLUSH, "br_lu_b");
        step(1, '0, RUN_O, "br_lu_b_after");
        step(1, mk(1, 5'd3, 5'd0, 5'd3, 1, 0, 0), BUB, "br_abort_bubble0");
        step(1, '0, BUB, "br_abort_bubble1");
        step(1, mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0), FLUSH, "br_abort_flush");
        step(1, '0, RUN_O, "br_abort_run");
        step(0, mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 1), FRZ, "busy_over_branch");
        step(0, mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1), FRZ, "busy_run");
        step(0, '0, RUN_O, "busy_release");
    endtask

    task automatic test_async_reset();
        step(1, mk(1, 5'd4, 5'd4, 5'd0, 0, 0, 0), BUB, "ar_bubble0");
        in_b = '0;
        #2;
        n_checks++;
        if (out_b !== BUB) begin n_fail++; $display("FAIL ar_in_stall: got %b, required %b", out_b, BUB); end
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (out_b !== ZERO) begin n_fail++; $display("FAIL ar_outputs_b: got %b, required %b", out_b, ZERO); end
        if (out_a !== ZERO) begin n_fail++; $display("FAIL ar_outputs_a: got %b, required %b", out_a, ZERO); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, '0, RUN_O, "ar_run_after_release");
        n_checks++;
        if (cnt_b !== 4'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d, required 0", cnt_b); end
    endtask

    task automatic test_perf_cnt();
        logic [3:0] exp_b;
`ifdef HAZARD_PERF_CNT_EN
        exp_b = 4'd15;
`else
        exp_b = 4'd0;
`endif
        apply_reset();
        for (int i = 0; i < 20; i++) step(1, mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1), FRZ, "perf_freeze");
        step(1, '0, RUN_O, "perf_release");
        n_checks += 2;
        if (cnt_b !== exp_b) begin n_fail++; $display("FAIL perf_cnt_b: got %0d, required %0d", cnt_b, exp_b); end
        if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL perf_cnt_a: got %0d, required 0", cnt_a); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_use_single();
        test_x0_rs2();
        test_load_stall_multi();
        test_branch();
        test_async_reset();
        test_perf_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
